mbist_march_ctrl: RTL and testbench
===================================

Name: mbist_march_ctrl

Overview:
Parametrised MBIST controller that sequences a full March C- test over a single-port synchronous SRAM. It drives address, write-enable and data-background patterns, and compares read data after a configurable read latency. It reports done and pass/fail. It sits between the BIST start/stop pins and the memory-wrapper test mux, and tmode selects the test path.

Parameters:
ADDR_W, 8, address width; memory depth is 2**ADDR_W words
DATA_W, 4, memory word width
RD_LAT, 1, memory read latency in cycles (1 or 2)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  level; begin test when IDLE
stop  in  1  abort test; return to IDLE
tmode  out  1  high whenever state != IDLE
mem_en  out  1  memory access strobe
mem_we  out  1  1=write, 0=read (valid when mem_en)
mem_addr  out  ADDR_W  access address
mem_wdata  out  DATA_W  write data, all-0 or all-1 background
mem_rdata  in  DATA_W  read data, valid RD_LAT cycles after read strobe
done  out  1  test complete, held in DONE
fail  out  1  sticky mismatch flag
fail_addr  out  ADDR_W  address of first mismatch
fail_elem  out  3  march element of first mismatch

Behaviour:
- Reset: state IDLE; all outputs 0.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN when start=1; element/address/op counters cleared and fail cleared on that edge.
  - RUN -> DRAIN after the final op is issued.
  - DRAIN lasts RD_LAT cycles, then -> DONE.
  - DONE -> IDLE when start=0.
  - stop=1 in any non-IDLE state -> IDLE next edge: done=0, fail retained, mem_en=0.
  - stop has priority over start; rst has priority over everything.
- March C- elements, one op per cycle, mem_en=1 throughout RUN:
  - M0 up (w0)
  - M1 up (r0,w1)
  - M2 up (r1,w0)
  - M3 down (r0,w1)
  - M4 down (r1,w0)
  - M5 up (r0)
- Total ops = 10*2**ADDR_W.
- Address order: "up" runs 0..2**ADDR_W-1; "down" runs max..0. The address counter wraps cleanly between elements; there is no idle cycle between elements.
- Background: "0" means DATA_W zeros; "1" means DATA_W ones.
- Compare pipeline: each read pushes {expected, addr, elem, valid} into an RD_LAT-deep shift register. At the tail, if valid and mem_rdata != expected:
  - fail is set;
  - the first such event captures fail_addr and fail_elem.
- Reads issued before a stop are still compared in the cycles after it; their compare updates fail.
- done=1 only in DONE. fail stays valid until the next start from IDLE or rst.
- mem_wdata is 0 whenever mem_we=0.

Optional Feature:
MBIST_DIAG_EN:
- Defined: fail_addr/fail_elem capture the first mismatch as described.
- Undefined: the capture registers are not built, and fail_addr/fail_elem are tied to 0. fail and done behave identically in both builds.

Decomposition:
- Package mbist_pkg holds:
  - state enum (IDLE/RUN/DRAIN/DONE);
  - element encoding M0..M5 (3 bits);
  - per-element constants: direction, op count, read-expected background, write background.
- One sub-module, mbist_addr_gen: an ADDR_W up/down counter with load-to-first-address and last-address flag.

Test Plan:
- Default params, fault-free memory model, start held high: RUN for 2560 cycles, then DRAIN 1 cycle, then done=1, fail=0, tmode=1. Lowering start returns to IDLE with tmode=0.
- Stuck-at-1 fault on bit0 at address 0x5A: fail=1, fail_addr=0x5A, fail_elem=1 (first r0). done still asserted after the full 2560+1 cycles.
- Coupling fault, where writing 1 to 0x10 flips 0x11 to 1: first mismatch reported at fail_addr=0x11, fail_elem=1.
- stop asserted at RUN cycle 700: tmode=0 and mem_en=0 on the next cycle, done never asserts. A restart gives a clean full pass with fail=0.
- RD_LAT=2, ADDR_W=3, DATA_W=8, fault-free: 80 ops, DRAIN 2 cycles, fail=0, and mem_addr follows 0..7 for M0-M2 and 7..0 for M3-M4.
- rst asserted mid-M3: all outputs 0 next cycle and state IDLE. Build without MBIST_DIAG_EN plus the stuck-at fault: fail=1, fail_addr=0.

Source files
------------

// File: rtl/mbist_pkg.sv
// Shared types and March C- element table for the MBIST controller.
// Elements: M0 up(w0), M1 up(r0,w1), M2 up(r1,w0), M3 down(r0,w1),
// M4 down(r1,w0), M5 up(r0).
package mbist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        M0 = 3'd0,
        M1 = 3'd1,
        M2 = 3'd2,
        M3 = 3'd3,
        M4 = 3'd4,
        M5 = 3'd5
    } elem_t;

    localparam elem_t LAST_ELEM = M5;

    // Address direction of an element: 1 = ascending, 0 = descending.
    function automatic logic elem_up(input elem_t e);
        return !((e == M3) || (e == M4));
    endfunction

    // Elements with a read followed by a write issue two ops per address.
    function automatic logic elem_two_ops(input elem_t e);
        return (e != M0) && (e != M5);
    endfunction

    // Background the read op of an element expects to find.
    function automatic logic elem_rd_bg(input elem_t e);
        return (e == M2) || (e == M4);
    endfunction

    // Background the write op of an element stores.
    function automatic logic elem_wr_bg(input elem_t e);
        return (e == M1) || (e == M3);
    endfunction

    // Op 0 is a read everywhere except the initialising M0; op 1 is always a write.
    function automatic logic op_is_write(input elem_t e, input logic op);
        logic w;
        if (e == M0)
            w = 1'b1;
        else if (e == M5)
            w = 1'b0;
        else
            w = op;
        return w;
    endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// Up/down address counter for the March sequencer. load jumps to the first
// address of the direction given by load_up; step walks one address in the
// direction given by up; last flags the final address of that direction.
module mbist_addr_gen
    import mbist_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              load_up,
    input  logic              step,
    input  logic              up,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    // Address register: load has priority over step.
    always_ff @(posedge clk) begin
        if (rst)
            addr <= '0;
        else if (load)
            addr <= load_up ? '0 : ADDR_MAX;
        else if (step)
            addr <= up ? (addr + 1'b1) : (addr - 1'b1);
    end

    assign last = up ? (addr == ADDR_MAX) : (addr == '0);

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- MBIST controller for a single-port synchronous SRAM.
// Sequences all six elements back to back, one op per cycle, and compares
// read data RD_LAT cycles after each read strobe.
// Optional build macro MBIST_DIAG_EN: when defined, the address and element
// of the first mismatch are captured on fail_addr/fail_elem; otherwise
// those outputs are tied to zero and the capture logic is not built.
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    output logic              tmode,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem
);

    localparam logic [1:0] DRAIN_LAST = 2'(RD_LAT - 1);
    localparam bit         LAT2       = (RD_LAT == 2);

    state_t            state, state_nxt;
    elem_t             elem, elem_nxt;
    logic              op, op_nxt;
    logic [1:0]        drain_cnt, drain_nxt;
    logic              ag_load, ag_load_up, ag_step;
    logic [ADDR_W-1:0] addr;
    logic              addr_last;
    logic              run, run_start, op_last, is_write, rd_push;

    mbist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .load    (ag_load),
        .load_up (ag_load_up),
        .step    (ag_step),
        .up      (elem_up(elem)),
        .addr    (addr),
        .last    (addr_last)
    );

    assign run      = (state == ST_RUN);
    assign op_last  = !elem_two_ops(elem) || op;
    assign is_write = op_is_write(elem, op);
    assign rd_push  = run && !is_write;

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            elem      <= M0;
            op        <= 1'b0;
            drain_cnt <= 2'd0;
        end else begin
            state     <= state_nxt;
            elem      <= elem_nxt;
            op        <= op_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    // Next-state logic: element/op sequencing and address-generator control.
    always_comb begin
        state_nxt  = state;
        elem_nxt   = elem;
        op_nxt     = op;
        drain_nxt  = drain_cnt;
        ag_load    = 1'b0;
        ag_load_up = 1'b1;
        ag_step    = 1'b0;
        run_start  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_nxt  = ST_RUN;
                    elem_nxt   = M0;
                    op_nxt     = 1'b0;
                    ag_load    = 1'b1;
                    ag_load_up = elem_up(M0);
                    run_start  = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (!op_last) begin
                    op_nxt = 1'b1;
                end else begin
                    op_nxt = 1'b0;
                    if (!addr_last) begin
                        ag_step = 1'b1;
                    end else if (elem == LAST_ELEM) begin
                        state_nxt = ST_DRAIN;
                        drain_nxt = 2'd0;
                    end else begin
                        // Element boundary: jump straight to the next element's
                        // first address so no idle cycle is inserted.
                        elem_nxt   = elem_t'(elem + 3'd1);
                        ag_load    = 1'b1;
                        ag_load_up = elem_up(elem_nxt);
                    end
                end
            end
            ST_DRAIN: begin
                if (stop)
                    state_nxt = ST_IDLE;
                else if (drain_cnt == DRAIN_LAST)
                    state_nxt = ST_DONE;
                else
                    drain_nxt = drain_cnt + 2'd1;
            end
            ST_DONE: begin
                if (stop || !start)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Memory-side outputs are only driven while the sequencer runs.
    always_comb begin
        tmode     = (state != ST_IDLE);
        done      = (state == ST_DONE);
        mem_en    = run;
        mem_we    = run && is_write;
        mem_addr  = run ? addr : '0;
        mem_wdata = (run && is_write) ? {DATA_W{elem_wr_bg(elem)}} : '0;
    end

    // ---- Stage p0: read issued this cycle, expected data captured ----
    logic              vld_p0, vld_p1, vld_tl;
    logic [DATA_W-1:0] exp_p0, exp_p1, exp_tl;
    logic              mismatch;

    // Valid pipeline; flushed when a new test starts.
    always_ff @(posedge clk) begin
        if (rst || run_start) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= rd_push;
            vld_p1 <= vld_p0;
        end
    end

    // Expected-data pipeline.
    always_ff @(posedge clk) begin
        exp_p0 <= {DATA_W{elem_rd_bg(elem)}};
        // ---- Stage p1: second latency cycle, used when RD_LAT = 2 ----
        exp_p1 <= exp_p0;
    end

    // ---- Tail stage: compare against returning read data ----
    assign vld_tl   = LAT2 ? vld_p1 : vld_p0;
    assign exp_tl   = LAT2 ? exp_p1 : exp_p0;
    assign mismatch = vld_tl && (mem_rdata != exp_tl);

    // Sticky fail flag, cleared only by reset or a fresh start.
    always_ff @(posedge clk) begin
        if (rst || run_start)
            fail <= 1'b0;
        else if (mismatch)
            fail <= 1'b1;
    end

`ifdef MBIST_DIAG_EN
    logic [ADDR_W-1:0] addr_p0, addr_p1, addr_tl;
    logic [2:0]        elem_p0, elem_p1, elem_tl;

    // Diagnostic address/element pipeline alongside expected data.
    always_ff @(posedge clk) begin
        addr_p0 <= addr;
        elem_p0 <= elem;
        addr_p1 <= addr_p0;
        elem_p1 <= elem_p0;
    end

    assign addr_tl = LAT2 ? addr_p1 : addr_p0;
    assign elem_tl = LAT2 ? elem_p1 : elem_p0;

    // Capture only the first mismatch of a test.
    always_ff @(posedge clk) begin
        if (rst || run_start) begin
            fail_addr <= '0;
            fail_elem <= 3'd0;
        end else if (mismatch && !fail) begin
            fail_addr <= addr_tl;
            fail_elem <= elem_tl;
        end
    end
`else
    assign fail_addr = '0;
    assign fail_elem = 3'd0;
`endif

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Self-checking bench for mbist_march_ctrl: one default-parameter instance
// with a fault-injectable memory, one small RD_LAT=2 instance.
module tb_mbist_march_ctrl;

`ifdef MBIST_DIAG_EN
    localparam bit DIAG = 1'b1;
`else
    localparam bit DIAG = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    // ---------------- instance A: ADDR_W=8 DATA_W=4 RD_LAT=1 ----------------
    logic       start, stop;
    logic       tmode, mem_en, mem_we, done, fail;
    logic [7:0] mem_addr, fail_addr;
    logic [3:0] mem_wdata, mem_rdata;
    logic [2:0] fail_elem;
    int         fault = 0;   // 0 none, 1 stuck-at-1 bit0 @0x5A, 2 coupling 0x10->0x11

    mbist_march_ctrl #(.ADDR_W(8), .DATA_W(4), .RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .tmode(tmode),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .done(done),
        .fail(fail), .fail_addr(fail_addr), .fail_elem(fail_elem)
    );

    logic [3:0] mema [256];
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            mema[mem_addr] <= mem_wdata;
            if (fault == 2 && mem_addr == 8'h10 && mem_wdata != 4'h0)
                mema[8'h11] <= 4'hF;
        end
        if (mem_en && !mem_we)
            mem_rdata <= mema[mem_addr] | ((fault == 1 && mem_addr == 8'h5A) ? 4'h1 : 4'h0);
    end

    // ---------------- instance B: ADDR_W=3 DATA_W=8 RD_LAT=2 ----------------
    logic       startb, stopb;
    logic       tmodeb, mem_enb, mem_web, doneb, failb;
    logic [2:0] mem_addrb, fail_addrb, fail_elemb;
    logic [7:0] mem_wdatab, mem_rdatab, rdb_s1;

    mbist_march_ctrl #(.ADDR_W(3), .DATA_W(8), .RD_LAT(2)) dut_b (
        .clk(clk), .rst(rst), .start(startb), .stop(stopb), .tmode(tmodeb),
        .mem_en(mem_enb), .mem_we(mem_web), .mem_addr(mem_addrb),
        .mem_wdata(mem_wdatab), .mem_rdata(mem_rdatab), .done(doneb),
        .fail(failb), .fail_addr(fail_addrb), .fail_elem(fail_elemb)
    );

    logic [7:0] memb [8];
    always @(posedge clk) begin
        if (mem_enb && mem_web)
            memb[mem_addrb] <= mem_wdatab;
        if (mem_enb && !mem_web)
            rdb_s1 <= memb[mem_addrb];
        mem_rdatab <= rdb_s1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Full test on instance A with start held high, then release start.
    task automatic run_full(input int flt, input int exp_run, input int exp_drain,
                            input logic exp_fail, input logic [7:0] exp_faddr,
                            input logic [2:0] exp_felem);
        int n;
        int d;
        @(negedge clk);
        fault = flt;
        start = 1'b1;
        @(negedge clk);
        check("first_run_cycle", {fail, mem_en, mem_we, mem_addr}, {1'b0, 1'b1, 1'b1, 8'h00});
        n = 0;
        while (mem_en && n < 3000) begin
            n++;
            @(negedge clk);
        end
        check("run_cycles", n, exp_run);
        d = 0;
        while (tmode && !done && d < 10) begin
            d++;
            @(negedge clk);
        end
        check("drain_cycles", d, exp_drain);
        check("done_state", {done, tmode, mem_en}, {1'b1, 1'b1, 1'b0});
        check("fail_flag", fail, exp_fail);
        check("fail_addr", fail_addr, exp_faddr);
        check("fail_elem", fail_elem, exp_felem);
        @(negedge clk);
        check("done_held", done, 1'b1);
        start = 1'b0;
        @(negedge clk);
        check("back_idle", {tmode, done}, 2'b00);
    endtask

    // Abort instance A during RUN cycle stop_at.
    task automatic run_stop(input int flt, input int stop_at, input logic exp_fail,
                            input logic [7:0] exp_faddr, input logic [2:0] exp_felem);
        logic saw_done;
        @(negedge clk);
        fault = flt;
        start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < stop_at; i++) @(negedge clk);
        check("running_before_stop", mem_en, 1'b1);
        stop  = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("stop_idle", {tmode, mem_en, done}, 3'b000);
        stop = 1'b0;
        @(negedge clk);
        check("stop_fail", fail, exp_fail);
        check("stop_fail_addr", fail_addr, exp_faddr);
        check("stop_fail_elem", fail_elem, exp_felem);
        saw_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            saw_done = saw_done | done | tmode;
        end
        check("no_done_after_stop", saw_done, 1'b0);
    endtask

    typedef struct {
        int         flt;
        int         exp_run;
        int         exp_drain;
        logic       exp_fail;
        logic [7:0] exp_faddr;
        logic [2:0] exp_felem;
    } vec_t;

    vec_t vecs [4];

    initial begin
        logic [2:0] felem;
        int         nb;
        int         d;

        vecs[0] = '{0, 2560, 1, 1'b0, 8'h00, 3'd0};
        vecs[1] = '{1, 2560, 1, 1'b1, DIAG ? 8'h5A : 8'h00, DIAG ? 3'd1 : 3'd0};
        vecs[2] = '{2, 2560, 1, 1'b1, DIAG ? 8'h11 : 8'h00, DIAG ? 3'd1 : 3'd0};
        vecs[3] = '{0, 2560, 1, 1'b0, 8'h00, 3'd0};
        felem   = DIAG ? 3'd1 : 3'd0;

        rst = 1'b1; start = 1'b0; stop = 1'b0; startb = 1'b0; stopb = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs_a", {tmode, mem_en, mem_we, mem_addr, mem_wdata, done, fail, fail_addr, fail_elem}, '0);
        check("reset_outputs_b", {tmodeb, mem_enb, mem_web, mem_addrb, mem_wdatab, doneb, failb, fail_addrb, fail_elemb}, '0);
        rst = 1'b0;

        // Start/stop priority: both high in IDLE keeps the controller idle.
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        check("stop_over_start", tmode, 1'b0);
        start = 1'b0; stop = 1'b0;

        for (int i = 0; i < 4; i++)
            run_full(vecs[i].flt, vecs[i].exp_run, vecs[i].exp_drain,
                     vecs[i].exp_fail, vecs[i].exp_faddr, vecs[i].exp_felem);

        // Abort mid-M1 on a clean memory, then a clean restart.
        run_stop(0, 700, 1'b0, 8'h00, 3'd0);
        run_full(0, 2560, 1, 1'b0, 8'h00, 3'd0);

        // Abort on the very cycle the faulty read is issued: it is still compared.
        run_stop(1, 436, 1'b1, DIAG ? 8'h5A : 8'h00, felem);

        // Reset in the middle of M3 with a fault already recorded.
        @(negedge clk);
        fault = 1;
        start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 1400; i++) @(negedge clk);
        check("pre_reset_fail", {fail, mem_en}, 2'b11);
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("midrun_reset", {tmode, mem_en, mem_we, mem_addr, mem_wdata, done, fail, fail_addr, fail_elem}, '0);
        rst = 1'b0;
        fault = 0;
        @(negedge clk);
        check("idle_after_reset", tmode, 1'b0);

        // Instance B: exact op sequence, two-cycle drain.
        @(negedge clk);
        startb = 1'b1;
        @(negedge clk);
        nb = 0;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < 8; i++) begin
                for (int k = 0; k < ((e == 0 || e == 5) ? 1 : 2); k++) begin
                    logic       up, wr, bg;
                    logic [2:0] a;
                    logic [7:0] wd;
                    up = !(e == 3 || e == 4);
                    a  = up ? 3'(i) : 3'(7 - i);
                    wr = (e == 0) || (k == 1);
                    bg = (e == 1 || e == 3);
                    wd = wr ? (bg ? 8'hFF : 8'h00) : 8'h00;
                    check("b_op", {mem_enb, mem_web, mem_addrb, mem_wdatab}, {1'b1, wr, a, wd});
                    nb++;
                    @(negedge clk);
                end
            end
        end
        check("b_op_count", nb, 80);
        d = 0;
        while (tmodeb && !doneb && d < 10) begin
            check("b_drain_quiet", mem_enb, 1'b0);
            d++;
            @(negedge clk);
        end
        check("b_drain_cycles", d, 2);
        check("b_done", {doneb, failb, fail_addrb, fail_elemb}, {1'b1, 1'b0, 3'd0, 3'd0});
        startb = 1'b0;
        @(negedge clk);
        check("b_idle", {tmodeb, doneb}, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
